// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helper functions for the pipeline
// hazard controller (hazard_ctrl) and its HI/LO busy sequencer (md_busy_seq).
package hazard_pkg;

  // Tuse encoding meaning "operand not read by this instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Forwarding mux select codes.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  typedef enum logic [0:0] {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  // A D-stage read of register a stalls when a producer in E or M will not
  // have its result ready by the time the reader needs it.
  function automatic logic reg_hazard(input logic [4:0] a, input logic [1:0] tuse,
                                      input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                      input logic [4:0] m_a3, input logic [1:0] m_tnew);
    return (a != 5'd0) && (tuse != TUSE_NONE) &&
           (((a == e_a3) && (e_tnew > tuse)) || ((a == m_a3) && (m_tnew > tuse)));
  endfunction

  // Youngest ready producer wins: E, then M, then W. $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic e_ok, input logic [4:0] e_a3,
                                         input logic m_ok, input logic [4:0] m_a3,
                                         input logic [4:0] w_a3);
    if (src == 5'd0) return FWD_RF;
    if (e_ok && (src == e_a3)) return FWD_E;
    if (m_ok && (src == m_a3)) return FWD_M;
    if (src == w_a3) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master: pipeline side (drives stage indices/Tuse/Tnew, reads controls)
//   slave : controller side (reads stage info, drives stall/enables/selects)
interface hazard_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  logic [4:0]        D_A1;
  logic [4:0]        D_A2;
  logic [1:0]        D_tuse_rs;
  logic [1:0]        D_tuse_rt;
  logic              D_md;
  logic [4:0]        E_A3;
  logic [1:0]        E_tnew;
  logic [4:0]        M_A3;
  logic [1:0]        M_tnew;
  logic [4:0]        W_A3;
  logic              E_md_start;
  logic              E_md_div;
  logic              stall;
  logic              F_en;
  logic              D_en;
  logic              E_clr;
  logic              md_busy;
  logic [1:0]        D_fwd1;
  logic [1:0]        D_fwd2;
  logic [1:0]        E_fwdA;
  logic [1:0]        E_fwdB;
  logic [1:0]        M_fwdWD;
  logic              md_overlap_err;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output D_A1, D_A2, D_tuse_rs, D_tuse_rt, D_md, E_A3, E_tnew, M_A3, M_tnew, W_A3,
           E_md_start, E_md_div,
    input  stall, F_en, D_en, E_clr, md_busy, D_fwd1, D_fwd2, E_fwdA, E_fwdB, M_fwdWD,
           md_overlap_err, stall_cnt
  );

  modport slave (
    input  D_A1, D_A2, D_tuse_rs, D_tuse_rt, D_md, E_A3, E_tnew, M_A3, M_tnew, W_A3,
           E_md_start, E_md_div,
    output stall, F_en, D_en, E_clr, md_busy, D_fwd1, D_fwd2, E_fwdA, E_fwdB, M_fwdWD,
           md_overlap_err, stall_cnt
  );
endinterface

// File: rtl/md_busy_seq.sv
// md_busy_seq: HI/LO multiply/divide busy sequencer.
//   clk, reset (async, active-low)
//   start       : mult/div instruction is in E this cycle
//   is_div      : qualifies start (1 = divide)
//   busy        : HI/LO unit busy
//   overlap_err : sticky, a start arrived while already busy
module md_busy_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic overlap_err
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          cnt_d   = is_div ? DIV_LD : MULT_LD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // A second start is never reloaded, even on the final busy cycle.
        if (start) err_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = MD_IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so an async reset drops it at once.
  assign busy        = (state_q == MD_BUSY);
  assign overlap_err = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage MIPS hazard and scheduling controller.
//   clk, reset (async, active-low)
//   hif (slave): D/E/M/W register indices, Tuse/Tnew, md start/div in;
//                stall, F_en/D_en, E_clr, md_busy, forward selects,
//                md_overlap_err and saturating stall_cnt out.
// E_fwdA/E_fwdB compare M/W destinations against D_A1/D_A2; the pipeline top
// feeds E-stage source indices there through a second instance. M_fwdWD uses
// D_A2 as the store-data source index the same way.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);

  logic              md_busy;
  logic              md_err;
  logic              rs_hz, rt_hz, md_hz, stall;
  logic [PERF_W-1:0] stall_cnt_q;

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk         (clk),
    .reset       (reset),
    .start       (hif.E_md_start),
    .is_div      (hif.E_md_div),
    .busy        (md_busy),
    .overlap_err (md_err)
  );

  always_comb begin
    rs_hz = reg_hazard(hif.D_A1, hif.D_tuse_rs, hif.E_A3, hif.E_tnew, hif.M_A3, hif.M_tnew);
    rt_hz = reg_hazard(hif.D_A2, hif.D_tuse_rt, hif.E_A3, hif.E_tnew, hif.M_A3, hif.M_tnew);
    // A mult/div entering E blocks a following HI/LO user before busy rises.
    md_hz = hif.D_md && (md_busy || hif.E_md_start);
    stall = rs_hz || rt_hz || md_hz;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign hif.stall          = stall;
  assign hif.F_en           = ~stall;
  assign hif.D_en           = ~stall;
  assign hif.E_clr          = stall;
  assign hif.md_busy        = md_busy;
  assign hif.md_overlap_err = md_err;
  assign hif.stall_cnt      = stall_cnt_q;

  assign hif.D_fwd1  = fwd_sel(hif.D_A1, hif.E_tnew == 2'd0, hif.E_A3,
                               hif.M_tnew == 2'd0, hif.M_A3, hif.W_A3);
  assign hif.D_fwd2  = fwd_sel(hif.D_A2, hif.E_tnew == 2'd0, hif.E_A3,
                               hif.M_tnew == 2'd0, hif.M_A3, hif.W_A3);
  assign hif.E_fwdA  = fwd_sel(hif.D_A1, 1'b0, hif.E_A3,
                               hif.M_tnew == 2'd0, hif.M_A3, hif.W_A3);
  assign hif.E_fwdB  = fwd_sel(hif.D_A2, 1'b0, hif.E_A3,
                               hif.M_tnew == 2'd0, hif.M_A3, hif.W_A3);
  assign hif.M_fwdWD = fwd_sel(hif.D_A2, 1'b0, hif.E_A3, 1'b0, hif.M_A3, hif.W_A3);

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int unsigned PW = 6;

  typedef struct {
    logic [4:0] a1, a2;
    logic [1:0] trs, trt;
    logic       md;
    logic [4:0] e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_a3;
    logic [1:0] m_tnew;
    logic [4:0] w_a3;
    logic       stall;
    logic [1:0] f1, f2, fa, fb, wd;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic exp_stall;
  logic [PW-1:0] exp_cnt;
  vec_t vecs[13];
  vec_t sb[$];

  hazard_ctrl_if #(.PERF_W(PW)) hif ();

  hazard_ctrl #(.PERF_W(PW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .hif   (hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference stall-cycle counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_cnt <= '0;
    else if (exp_stall && (exp_cnt != {PW{1'b1}})) exp_cnt <= exp_cnt + 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic vec_t mk(int a1, int a2, int trs, int trt, int md, int e_a3, int e_tnew,
                              int m_a3, int m_tnew, int w_a3, int st, int f1, int f2,
                              int fa, int fb, int wd);
    vec_t v;
    v.a1 = 5'(a1); v.a2 = 5'(a2); v.trs = 2'(trs); v.trt = 2'(trt); v.md = 1'(md);
    v.e_a3 = 5'(e_a3); v.e_tnew = 2'(e_tnew); v.m_a3 = 5'(m_a3); v.m_tnew = 2'(m_tnew);
    v.w_a3 = 5'(w_a3); v.stall = 1'(st);
    v.f1 = 2'(f1); v.f2 = 2'(f2); v.fa = 2'(fa); v.fb = 2'(fb); v.wd = 2'(wd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hif.D_A1 = v.a1; hif.D_A2 = v.a2; hif.D_tuse_rs = v.trs; hif.D_tuse_rt = v.trt;
    hif.D_md = v.md; hif.E_A3 = v.e_a3; hif.E_tnew = v.e_tnew; hif.M_A3 = v.m_a3;
    hif.M_tnew = v.m_tnew; hif.W_A3 = v.w_a3;
    hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
    exp_stall = v.stall;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    check("stall", 32'(hif.stall), 32'(e.stall));
    check("F_en", 32'(hif.F_en), 32'(!e.stall));
    check("D_en", 32'(hif.D_en), 32'(!e.stall));
    check("E_clr", 32'(hif.E_clr), 32'(e.stall));
    check("D_fwd1", 32'(hif.D_fwd1), 32'(e.f1));
    check("D_fwd2", 32'(hif.D_fwd2), 32'(e.f2));
    check("E_fwdA", 32'(hif.E_fwdA), 32'(e.fa));
    check("E_fwdB", 32'(hif.E_fwdB), 32'(e.fb));
    check("M_fwdWD", 32'(hif.M_fwdWD), 32'(e.wd));
    check("stall_cnt", 32'(hif.stall_cnt), 32'(exp_cnt));
  endtask

  // One mult/div start, optional second start at step 'second', then n+1 observed cycles.
  task automatic run_md(input logic div, input int n, input int second, input logic dmd,
                        input logic err0);
    logic exp_err;
    @(negedge clk);
    drive(mk(0, 0, 3, 3, dmd, 0, 0, 0, 0, 0, dmd, 0, 0, 0, 0, 0));
    hif.E_md_start = 1'b1;
    hif.E_md_div = div;
    #1;
    check("md_busy_pre", 32'(hif.md_busy), 32'd0);
    check("md_stall_start", 32'(hif.stall), 32'(dmd));
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      hif.E_md_start = (i == second);
      exp_stall = dmd && ((i <= n) || (i == second));
      exp_err = err0 || ((second != 0) && (second <= n) && (i > second));
      #1;
      check("md_busy", 32'(hif.md_busy), 32'(i <= n));
      check("md_stall", 32'(hif.stall), 32'(exp_stall));
      check("md_overlap_err", 32'(hif.md_overlap_err), 32'(exp_err));
      check("md_stall_cnt", 32'(hif.stall_cnt), 32'(exp_cnt));
    end
    hif.E_md_start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    //            a1 a2 trs trt md eA3 eTn mA3 mTn wA3 | st f1 f2 fA fB wd
    vecs[0]  = mk( 0, 0, 3, 3, 0,  0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk( 8, 0, 1, 3, 0,  8, 2,  0, 0,  0,  1, 0, 0, 0, 0, 0);
    vecs[2]  = mk( 8, 0, 1, 3, 0,  8, 0,  0, 0,  0,  0, 3, 0, 0, 0, 0);
    vecs[3]  = mk( 0, 0, 1, 3, 0,  0, 2,  0, 0,  0,  0, 0, 0, 0, 0, 0);
    vecs[4]  = mk( 0, 5, 3, 0, 0,  5, 0,  5, 0,  5,  0, 0, 3, 0, 2, 1);
    vecs[5]  = mk( 0, 5, 3, 0, 0,  5, 1,  5, 0,  5,  1, 0, 2, 0, 2, 1);
    vecs[6]  = mk( 9, 0, 0, 3, 0,  0, 0,  9, 1,  9,  1, 1, 0, 1, 0, 0);
    vecs[7]  = mk( 9, 0, 1, 3, 0,  9, 1,  9, 1,  9,  0, 1, 0, 1, 0, 0);
    vecs[8]  = mk( 7, 0, 3, 3, 0,  7, 2,  0, 0,  0,  0, 0, 0, 0, 0, 0);
    vecs[9]  = mk( 0,12, 3, 1, 0, 12, 2,  0, 0, 12,  1, 0, 1, 0, 1, 1);
    vecs[10] = mk( 3, 4, 0, 0, 0,  0, 0,  3, 0,  4,  0, 2, 1, 2, 1, 1);
    vecs[11] = mk( 6, 0, 2, 3, 0,  6, 2,  0, 0,  0,  0, 0, 0, 0, 0, 0);
    vecs[12] = mk( 0, 0, 3, 3, 1,  0, 0,  0, 0,  0,  0, 0, 0, 0, 0, 0);

    // Reset state.
    rst_n = 1'b0;
    drive(vecs[0]);
    #3;
    check("rst_md_busy", 32'(hif.md_busy), 32'd0);
    check("rst_overlap_err", 32'(hif.md_overlap_err), 32'd0);
    check("rst_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    check("rst_stall", 32'(hif.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Divide with a HI/LO user waiting in D.
    run_md(1'b1, 10, 0, 1'b1, 1'b0);
    // Multiply, second start two cycles later.
    run_md(1'b0, 5, 2, 1'b0, 1'b0);

    // Saturating stall counter.
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      drive(vecs[1]);
    end
    #1;
    check("stall_cnt_sat", 32'(hif.stall_cnt), 32'd63);

    // Reset on the third busy cycle of a divide.
    @(negedge clk);
    drive(vecs[0]);
    hif.E_md_start = 1'b1;
    hif.E_md_div = 1'b1;
    @(negedge clk);
    hif.E_md_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("busy_before_rst", 32'(hif.md_busy), 32'd1);
    #2;
    drive(vecs[1]);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(hif.md_busy), 32'd0);
    check("rst_mid_cnt", 32'(hif.stall_cnt), 32'd0);
    check("rst_mid_err", 32'(hif.md_overlap_err), 32'd0);
    check("rst_comb_stall", 32'(hif.stall), 32'd1);
    check("rst_comb_E_clr", 32'(hif.E_clr), 32'd1);
    @(negedge clk);
    drive(vecs[0]);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", 32'(hif.md_busy), 32'd0);
      check("post_rst_cnt", 32'(hif.stall_cnt), 32'(exp_cnt));
    end

    // Second start on the final busy cycle: flagged, no reload.
    run_md(1'b0, 5, 5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and scheduling controller for the 5-stage MIPS pipeline.
- Compares Tuse of the instruction in D against Tnew of the producers in E and M, and generates the stall, enable and bubble controls. The E-stage register uses the bubble control as its stall/clear input.
- Owns the HI/LO multiply/divide busy sequencer and the forwarding mux selects for D, E and M.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after div/divu leaves E.
- CNT_W, 4, width of the md busy counter; must hold DIV_CYCLES.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- D_A1  in  5  rs index of the instruction in D.
- D_A2  in  5  rt index of the instruction in D.
- D_tuse_rs  in  2  Tuse for rs: 0/1/2; 3 = rs not read.
- D_tuse_rt  in  2  Tuse for rt: 0/1/2; 3 = rt not read.
- D_md  in  1  instruction in D uses HI/LO (mult*/div*/mfhi/mflo/mthi/mtlo).
- E_A3  in  5  destination of the instruction in E; 0 = none.
- E_tnew  in  2  cycles until the E result is ready (0..2).
- M_A3  in  5  destination of the instruction in M.
- M_tnew  in  2  cycles until the M result is ready (0..1).
- W_A3  in  5  destination of the instruction in W.
- E_md_start  in  1  instruction in E is mult/multu/div/divu.
- E_md_div  in  1  qualifies E_md_start: 1 = divide, 0 = multiply.
- stall  out  1  hazard detected this cycle.
- F_en  out  1  PC write enable; equals ~stall.
- D_en  out  1  D-register write enable; equals ~stall.
- E_clr  out  1  bubble insert into the E register; equals stall.
- md_busy  out  1  HI/LO unit busy.
- D_fwd1  out  2  D comparator rs source select.
- D_fwd2  out  2  D comparator rt source select.
- E_fwdA  out  2  ALU A source select.
- E_fwdB  out  2  ALU B source select.
- M_fwdWD  out  2  M store-data source select.
- md_overlap_err  out  1  sticky error flag.
- stall_cnt  out  PERF_W  stall-cycle count.

Behaviour:
- Stall, enables and forward selects are combinational from the inputs and registered state; there is no added latency.
- Register hazard for rs:
  - Condition: D_A1 != 0, D_tuse_rs != 3, and either (D_A1 == E_A3 and E_tnew > D_tuse_rs) or (D_A1 == M_A3 and M_tnew > D_tuse_rs).
  - The rt hazard is identical, using D_A2 and D_tuse_rt.
- md hazard: D_md and (md_busy or E_md_start).
- stall = rs hazard OR rt hazard OR md hazard.
- Forward select codes: 0 = register file/pipe value, 1 = W, 2 = M, 3 = E.
  - Priority is E over M over W. Source index 0 always selects code 0.
  - E is eligible only when E_tnew == 0; M only when M_tnew == 0.
  - D selects consider E, M and W. E selects consider M and W; for E selects, M_A3/W_A3 are compared against the E-stage source indices, which the top level supplies on the D_A1/D_A2 pins through a second instance. M_fwdWD considers W only.
- md sequencer FSM:
  - States IDLE and BUSY; cnt is CNT_W bits.
  - IDLE: on E_md_start, load cnt with DIV_CYCLES if E_md_div else MULT_CYCLES, then go to BUSY.
  - BUSY: decrement cnt each cycle; when cnt == 1, the next state is IDLE with cnt = 0.
  - md_busy = (state == BUSY). A start observed at edge k holds md_busy high for exactly N cycles.
  - E_md_start while BUSY is ignored (the counter is not reloaded) and sets md_overlap_err, which stays set until reset.
- stall_cnt increments each cycle stall = 1 and saturates at all-ones.
- Reset (async, active-low): FSM goes to IDLE; cnt = 0, md_busy = 0, md_overlap_err = 0, stall_cnt = 0.
  - Combinational outputs follow the inputs during reset.
  - Reset asserted mid-BUSY drops md_busy immediately, not at the next edge.
- Simultaneous events:
  - An E_md_start on the cycle the counter reaches cnt == 1 is an overlap: it is flagged and no reload occurs.
  - A register hazard and an md hazard together produce a single stall.

Decomposition:
- Shared package hazard_pkg holds:
  - TUSE_NONE = 2'd3.
  - FWD_RF, FWD_W, FWD_M, FWD_E codes.
  - md_state_t enum {MD_IDLE, MD_BUSY}.
- One natural sub-module: md_busy_seq, containing the FSM, the counter and the overlap flag.

Test Plan:
- Load-use: E_A3 = 8, E_tnew = 2, D_A1 = 8, D_tuse_rs = 1 -> stall = 1, F_en = 0, D_en = 0, E_clr = 1. Next cycle with E_tnew = 0 -> stall = 0, D_fwd1 = 3.
- $0 immunity: D_A1 = 0, E_A3 = 0, E_tnew = 2 -> stall = 0, D_fwd1 = 0.
- Forward priority: E_A3 = M_A3 = W_A3 = 5, E_tnew = 0, M_tnew = 0, D_A2 = 5, D_tuse_rt = 0 -> D_fwd2 = 3. With E_tnew = 1 -> stall = 1 (1 > 0).
- Divide busy: E_md_start = 1, E_md_div = 1 for one cycle -> md_busy high exactly 10 cycles. D_md = 1 during that window -> stall = 1. On cycle 11 -> stall = 0.
- Overlap: start a mult, then E_md_start = 1 two cycles later -> md_overlap_err = 1 and stays set; md_busy still falls 5 cycles after the first start.
- Reset mid-op: pull reset to 0 on the 3rd BUSY cycle -> md_busy = 0 and stall_cnt = 0 asynchronously. Release reset -> FSM is IDLE.
